// File: rtl/rng_result_history.sv
// Settled-result history for the lab1 RNG: captures each value that changes and then
// holds for SETTLE_CYCLES, keeps the last DEPTH results, and shows one on two 7-seg digits.
module rng_result_history #(
    parameter int SETTLE_CYCLES = 16,
    parameter int DEPTH         = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [3:0]                   i_value,
    input  logic                         i_browse,
    input  logic                         i_clear,
    output logic [6:0]                   o_seg_tens,
    output logic [6:0]                   o_seg_ones,
    output logic [$clog2(DEPTH)-1:0]     o_view,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_new,
    output logic                         o_busy
);

    localparam int VW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES);

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  COUNT_FULL  = CW'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [3:0]       last_q,   last_d;
    logic [SCW-1:0]   stable_q, stable_d;
    logic [VW-1:0]    wr_q,     wr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [VW-1:0]    view_q,   view_d;
    logic             new_q,    new_d;
    logic [3:0]       mem_q [DEPTH];

    logic             cap_s;
    logic [CW-1:0]    view_inc_s;
    logic [VW-1:0]    rd_idx_s;
    logic [3:0]       disp_val_s;
    logic [3:0]       ones_val_s;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Next-state logic; clear beats capture, capture beats browse and change detection.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        stable_d   = stable_q;
        wr_d       = wr_q;
        count_d    = count_q;
        view_d     = view_q;
        new_d      = 1'b0;
        cap_s      = 1'b0;
        view_inc_s = CW'(view_q) + CW'(1);
        if (i_clear) begin
            count_d  = '0;
            wr_d     = '0;
            view_d   = '0;
            stable_d = '0;
            state_d  = S_IDLE;
            last_d   = i_value;
        end else if ((state_q == S_TRACK) && (i_value == last_q) && (stable_q == SETTLE_LAST)) begin
            cap_s    = 1'b1;
            wr_d     = wr_q + VW'(1);
            count_d  = (count_q == COUNT_FULL) ? count_q : (count_q + CW'(1));
            view_d   = '0;
            new_d    = 1'b1;
            stable_d = '0;
            state_d  = S_IDLE;
        end else begin
            if (i_browse && (count_q != '0)) begin
                view_d = (view_inc_s == count_q) ? '0 : view_inc_s[VW-1:0];
            end else begin
                view_d = view_q;
            end
            if (i_value != last_q) begin
                last_d   = i_value;
                stable_d = '0;
                state_d  = S_TRACK;
            end else if (state_q == S_TRACK) begin
                stable_d = stable_q + SCW'(1);
            end else begin
                stable_d = stable_q;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 4'd0;
            stable_q <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            view_q   <= '0;
            new_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            view_q   <= view_d;
            new_q    <= new_d;
        end
    end

    // History storage needs no reset: an empty history is never displayed.
    always_ff @(posedge i_clk) begin
        if (cap_s) begin
            mem_q[wr_q] <= last_q;
        end
    end

    // Display decode of the selected entry, newest at offset 0.
    always_comb begin
        rd_idx_s   = wr_q - VW'(1) - view_q;
        disp_val_s = mem_q[rd_idx_s];
        ones_val_s = (disp_val_s >= 4'd10) ? (disp_val_s - 4'd10) : disp_val_s;
        if (count_q == '0) begin
            o_seg_tens = 7'h7F;
            o_seg_ones = 7'h7F;
        end else begin
            o_seg_tens = (disp_val_s >= 4'd10) ? 7'b1111001 : 7'h7F;
            o_seg_ones = seg7(ones_val_s);
        end
    end

    assign o_view  = view_q;
    assign o_count = count_q;
    assign o_new   = new_q;
    assign o_busy  = (state_q == S_TRACK);

endmodule

// File: tb/tb_rng_result_history.sv
// Randomised and directed bench for rng_result_history with a queue-based history model
// and a scoreboard monitor that pairs each o_new pulse with a predicted capture.
module tb_rng_result_history;

    localparam int SETTLE = 16;
    localparam int DEPTH  = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_value;
    logic       i_browse;
    logic       i_clear;
    logic [6:0] o_seg_tens;
    logic [6:0] o_seg_ones;
    logic [1:0] o_view;
    logic [2:0] o_count;
    logic       o_new;
    logic       o_busy;

    rng_result_history #(.SETTLE_CYCLES(SETTLE), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_value(i_value), .i_browse(i_browse),
        .i_clear(i_clear), .o_seg_tens(o_seg_tens), .o_seg_ones(o_seg_ones),
        .o_view(o_view), .o_count(o_count), .o_new(o_new), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [3:0] val; int cnt; } exp_t;
    exp_t       exp_q[$];
    logic [3:0] hist[$];
    int         m_view;
    logic [3:0] m_last;
    bit         m_armed;
    int         m_run;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] exp_disp(input int cnt, input int v);
        if (cnt == 0) return 14'h3FFF;
        return {((v >= 10) ? 7'b1111001 : 7'h7F), seg(v % 10)};
    endfunction

    function automatic logic [13:0] model_disp();
        if (hist.size() == 0) return 14'h3FFF;
        return exp_disp(hist.size(), int'(hist[hist.size() - 1 - m_view]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_view  = 0;
        m_last  = 4'd0;
        m_armed = 1'b0;
        m_run   = 0;
    endtask

    // Effect of one clock edge on the history, from the block's rules.
    task automatic model_edge(input logic [3:0] v, input logic b, input logic c);
        if (c) begin
            hist.delete();
            m_view = 0; m_last = v; m_armed = 1'b0; m_run = 0;
        end else if (m_armed && v == m_last && m_run == SETTLE - 1) begin
            hist.push_back(m_last);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            m_view = 0; m_armed = 1'b0; m_run = 0;
            exp_q.push_back('{m_last, hist.size()});
        end else begin
            if (b && hist.size() > 0) m_view = (m_view + 1) % hist.size();
            if (v != m_last) begin
                m_last = v; m_armed = 1'b1; m_run = 0;
            end else if (m_armed) begin
                m_run++;
            end
        end
    endtask

    task automatic step(input logic [3:0] v, input logic b, input logic c);
        i_value  = v;
        i_browse = b;
        i_clear  = c;
        @(posedge i_clk);
        model_edge(v, b, c);
        #1;
        i_browse = 1'b0;
        i_clear  = 1'b0;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int k = 0; k < n; k++) step(v, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: pair each o_new with a predicted capture, then compare full state.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_new) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL new_unexpected actual=1 expected=0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cap_disp", {o_seg_tens, o_seg_ones}, exp_disp(e.cnt, int'(e.val)));
                    check("cap_count", o_count, e.cnt);
                    check("cap_view", o_view, 0);
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                total++; bad++;
                $display("FAIL new_missing actual=0 expected=1 at %0t", $time);
            end
            check("state", {o_seg_tens, o_seg_ones, o_view, o_count, o_busy},
                  {model_disp(), 2'(m_view), 3'(hist.size()), m_armed});
        end
    end

    task automatic mid_reset();
        i_rst_n = 1'b0;
        #1;
        check("rst_tens", o_seg_tens, 7'h7F);
        check("rst_ones", o_seg_ones, 7'h7F);
        check("rst_view", o_view, 0);
        check("rst_count", o_count, 0);
        check("rst_new", o_new, 0);
        check("rst_busy", o_busy, 0);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    logic [3:0] seq_vals[5];
    logic [3:0] rv;
    logic [3:0] browse_vals[5];

    initial begin
        i_rst_n = 1'b0; i_value = 4'd0; i_browse = 1'b0; i_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        hold(4'd0, 50);
        check("idle_count", o_count, 0);
        check("idle_disp", {o_seg_tens, o_seg_ones}, 14'h3FFF);
        check("idle_busy", o_busy, 0);

        step(4'd15, 1'b0, 1'b0);
        check("busy_after_change", o_busy, 1);
        hold(4'd15, 15);
        check("new_at_settle", o_new, 0);
        step(4'd15, 1'b0, 1'b0);
        check("new_pulse", o_new, 1);
        check("tens_15", o_seg_tens, 7'b1111001);
        check("ones_15", o_seg_ones, 7'b0010010);
        check("count_1", o_count, 1);
        step(4'd15, 1'b0, 1'b0);
        check("new_single", o_new, 0);

        for (int k = 14; k >= 10; k--) hold(4'(k), 3);
        hold(4'd1, 20);
        check("count_after_seq", o_count, 2);
        check("seq_disp", {o_seg_tens, o_seg_ones}, {7'h7F, 7'b1111001});

        seq_vals = '{4'd3, 4'd7, 4'd9, 4'd12, 4'd4};
        foreach (seq_vals[k]) hold(seq_vals[k], 18);
        check("count_full", o_count, 4);
        browse_vals = '{4'd4, 4'd12, 4'd9, 4'd7, 4'd4};
        for (int k = 0; k < 5; k++) begin
            check("browse_view", o_view, k % 4);
            check("browse_disp", {o_seg_tens, o_seg_ones}, exp_disp(4, int'(browse_vals[k])));
            if (k < 4) begin
                step(4'd4, 1'b1, 1'b0);
                step(4'd4, 1'b0, 1'b0);
            end
        end

        step(4'd4, 1'b1, 1'b0);
        hold(4'd8, 16);
        step(4'd8, 1'b1, 1'b0);
        check("capbrowse_view", o_view, 0);
        check("capbrowse_disp", {o_seg_tens, o_seg_ones}, exp_disp(4, 8));
        check("capbrowse_new", o_new, 1);

        hold(4'd2, 5);
        step(4'd2, 1'b0, 1'b1);
        check("clear_count", o_count, 0);
        check("clear_disp", {o_seg_tens, o_seg_ones}, 14'h3FFF);
        check("clear_busy", o_busy, 0);
        hold(4'd2, 20);
        check("clear_nocap", o_count, 0);

        hold(4'd5, 18);
        hold(4'd6, 18);
        check("pre_reset_count", o_count, 2);
        hold(4'd0, 5);
        check("pre_reset_busy", o_busy, 1);
        mid_reset();
        hold(4'd0, 25);
        check("post_reset_nocap", o_count, 0);
        hold(4'd6, 18);
        check("post_reset_cap", o_count, 1);

        rv = 4'd9;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 23) == 0) rv = 4'($urandom_range(0, 15));
            step(rv, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
        end
        hold(rv, 2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_captures actual=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_result_history.md
# rng_result_history

Consumer for the lab1 random-number generator's 4-bit output. It watches the generator's value bus and detects when a shuffle has settled, meaning the value has changed and then held steady for a programmable number of cycles. Each settled value goes into a small circular history. The block drives two active-low seven-segment digits (decimal 0–15) showing the newest result, or an older one selected by a browse button.

## Interface
- SETTLE_CYCLES, 16: consecutive stable cycles required before capture; ≥2.
- DEPTH, 4: history entries; power of two, ≥2.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: asynchronous, active-low (clock i_clk).
- i_value  in  4  generator output; synchronous to i_clk.
- i_browse  in  1  one-cycle pulse (already debounced); step to the next-older entry.
- i_clear  in  1  one-cycle pulse; empty the history.
- o_seg_tens  out  7  tens digit, active-low, bit order gfedcba.
- o_seg_ones  out  7  ones digit, active-low, gfedcba.
- o_view  out  $clog2(DEPTH)  displayed offset; 0 is newest.
- o_count  out  $clog2(DEPTH+1)  valid entries, saturates at DEPTH.
- o_new  out  1  one-cycle pulse in the cycle after a capture.
- o_busy  out  1  high while in S_TRACK.

## Operation
- Registers:
  - last_r [3:0], reset 0
  - stable_cnt, reset 0
  - state, reset S_IDLE
  - mem[DEPTH]
  - wr_ptr, reset 0
  - count_r, reset 0
  - view_r, reset 0
  - new_r, reset 0
- Change detection runs every cycle. If i_value ≠ last_r: last_r ← i_value, stable_cnt ← 0, state ← S_TRACK. No capture occurs on that edge.
- S_IDLE, when i_value == last_r: hold.
- S_TRACK, when i_value == last_r:
  - If stable_cnt == SETTLE_CYCLES−1: capture last_r, stable_cnt ← 0, state ← S_IDLE.
  - Otherwise stable_cnt ← stable_cnt+1.
- Capture actions:
  - mem[wr_ptr] ← last_r.
  - wr_ptr ← wr_ptr+1 mod DEPTH.
  - count_r ← min(count_r+1, DEPTH).
  - view_r ← 0.
  - new_r ← 1. new_r is 0 on every non-capture edge.
- Full history: the oldest entry is silently overwritten. Duplicate values are captured normally; any change followed by settling is a new result.
- Browse: if count_r == 0, ignore. Otherwise view_r ← (view_r+1) mod count_r, so it wraps from the oldest entry back to the newest.
- Displayed entry: mem[(wr_ptr−1−view_r) mod DEPTH].
- Display decode is combinational from registers:
  - If count_r == 0, both digits are 7'h7F (blank).
  - Otherwise the value v in 0–15 splits as tens = (v ≥ 10), ones = v − 10·tens.
  - Tens digit: blank when v < 10, else "1".
- Segment codes (gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Priority: i_clear > capture > browse > change detect.
  - i_clear: count_r, wr_ptr, view_r, stable_cnt ← 0; state ← S_IDLE; last_r ← i_value. Any in-progress track is discarded and no capture occurs.
  - Capture and browse on the same edge: the capture wins and view_r ends at 0.
- Reset mid-track: all registers return to reset values immediately (asynchronous). mem contents are don't-care because count_r = 0.

## Timing
- Suppose i_value first equals V at edge E (≠ last_r) and holds. Then:
  - last_r = V after edge E.
  - Capture occurs at edge E+SETTLE_CYCLES.
  - o_new is high, o_count is updated and the digits show V during the cycle after that edge.
- A change at any edge before the capture restarts the count from that edge. Values that keep changing every cycle are never captured.
- Browse: o_view and the digits update in the cycle after the pulse edge.
- Clear: outputs are blank and o_count = 0 in the cycle after the pulse edge.
- All outputs are registered or pure decode of registers. There is no combinational path from any input to any output.
- Reset output values: o_seg_tens = o_seg_ones = 7'h7F; o_view, o_count, o_new, o_busy = 0.

## Test plan
Bench configuration: SETTLE_CYCLES=16, DEPTH=4.
- Reset, then hold i_value = 0 for 50 cycles → digits stay 7'h7F, o_count = 0, o_busy = 0, o_new never pulses.
- Step i_value 0→15 at edge E and hold → o_busy from E+1; at E+16, o_new is a single pulse, o_seg_tens = 1111001, o_seg_ones = 0010010, o_count = 1.
- Drive the sequence 15, 14, 13, 12, 11, 10, 1, changing every 3 cycles, then hold 1 → exactly one capture; tens blank, ones = 1111001.
- Capture 3, 7, 9, 12, 4, then browse 4 times → o_count = 4; displayed values 4 → 12 → 9 → 7 → 4; o_view 0 → 1 → 2 → 3 → 0; value 3 was overwritten.
- Pulse i_browse on the capture edge → o_view = 0 and the new value is shown. Pulse i_clear 5 cycles into a track → no capture, digits blank, o_busy = 0.
- Deassert i_rst_n mid-track with o_count = 2 → all outputs reach their reset values immediately. After release, a held value does not capture until it changes.
